countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 80 ++++++++
 tb/tb_countdown_timer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot and auto-reload modes, pause, abort and a
// registered terminal-count flag.
module countdown_timer #(
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] load_val,
    input  logic                   auto_reload,
    input  logic                   pause,
    input  logic                   abort,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] reload_val;
    logic                   reload_mode;

    // Priority: reset, then abort, then the per-state behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            reload_val  <= '0;
            reload_mode <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        count       <= load_val;
                        reload_val  <= load_val;
                        reload_mode <= auto_reload;
                        busy        <= 1'b1;
                        done        <= (load_val == '0);
                    end
                end
                RUN: begin
                    if (count == '0) begin
                        // Terminal cycle: pause has no effect here.
                        if (reload_mode) begin
                            count <= reload_val;
                            done  <= (reload_val == '0);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b0;
                        end
                    end else if (pause) begin
                        done <= 1'b0;
                    end else begin
                        count <= count - COUNT_WIDTH'(1);
                        done  <= (count == COUNT_WIDTH'(1));
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic, all checked
// against an elapsed-steps model of the countdown.
module tb_countdown_timer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         auto_reload = 1'b0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int checks = 0;
    int failures = 0;

    // Model: a countdown is its load value plus how many edges have advanced it.
    bit m_run = 1'b0;
    int m_l = 0;
    bit m_mode = 1'b0;
    int m_active = 0;

    countdown_timer #(.COUNT_WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .load_val(load_val),
        .auto_reload(auto_reload),
        .pause(pause),
        .abort(abort),
        .count(count),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic int exp_count();
        return m_run ? (m_l - (m_active % (m_l + 1))) : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit ar, input bit p,
                              input bit a, input int lv);
        if (r || a) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            if (s) begin
                m_run    = 1'b1;
                m_l      = lv;
                m_mode   = ar;
                m_active = 0;
            end
        end else begin
            if (!p || exp_count() == 0) m_active++;
            if (!m_mode && m_active == m_l + 1) m_run = 1'b0;
        end
    endtask

    // One clock: drive on the falling edge, update the model at the rising edge,
    // compare all outputs 1 time unit later.
    task automatic cycle(input string tag, input bit r, input bit s, input bit ar,
                         input bit p, input bit a, input logic [W-1:0] lv);
        @(negedge clk);
        rst = r; start = s; auto_reload = ar; pause = p; abort = a; load_val = lv;
        @(posedge clk);
        model_edge(r, s, ar, p, a, int'(lv));
        #1;
        chk({tag, ".count"}, 32'(count), 32'(exp_count()));
        chk({tag, ".busy"}, 32'(busy), 32'(m_run));
        chk({tag, ".done"}, 32'(done), 32'(m_run && exp_count() == 0));
    endtask

    initial begin
        int n;

        // Reset
        cycle("rst", 1, 0, 0, 0, 0, 8'd0);
        cycle("rst", 1, 1, 1, 1, 1, 8'd5);
        chk("rst_count", 32'(count), 32'd0);
        cycle("idle", 0, 0, 0, 0, 0, 8'd9);

        // One-shot from 3
        cycle("os_start", 0, 1, 0, 0, 0, 8'd3);
        chk("os_first", 32'(count), 32'd3);
        for (int i = 2; i >= 0; i--) begin
            cycle("os_run", 0, 0, 0, 0, 0, 8'd3);
            chk("os_seq", 32'(count), 32'(i));
            chk("os_done", 32'(done), 32'(i == 0));
        end
        cycle("os_end", 0, 0, 0, 0, 0, 8'd3);
        chk("os_busy_low", 32'(busy), 32'd0);
        cycle("os_hold", 0, 0, 0, 0, 0, 8'd3);
        chk("os_hold_count", 32'(count), 32'd0);

        // Periodic 2 with load_val changed to 7 mid-run
        cycle("per_start", 0, 1, 1, 0, 0, 8'd2);
        for (int i = 1; i <= 9; i++) begin
            cycle("per_run", 0, 1, 0, 0, 0, 8'd7);
            chk("per_seq", 32'(count), 32'(2 - (i % 3)));
            chk("per_done", 32'(done), 32'((i % 3) == 2));
        end
        cycle("per_abort", 0, 0, 0, 0, 1, 8'd7);

        // Pause for 2 cycles at count 5 from 9
        n = 1;
        cycle("pz_start", 0, 1, 0, 0, 0, 8'd9);
        for (int i = 0; i < 4; i++) begin
            cycle("pz_run", 0, 0, 0, 0, 0, 8'd9);
            n++;
        end
        chk("pz_at5", 32'(count), 32'd5);
        for (int i = 0; i < 2; i++) begin
            cycle("pz_pause", 0, 0, 0, 1, 0, 8'd9);
            n++;
            chk("pz_hold", 32'(count), 32'd5);
        end
        while (!done && n < 30) begin
            cycle("pz_run", 0, 0, 0, 0, 0, 8'd9);
            n++;
        end
        chk("pz_latency", 32'(n), 32'd12);
        cycle("pz_end", 0, 0, 0, 0, 0, 8'd9);

        // Load of zero: one-shot pulse, then continuous done in reload mode
        cycle("z_os", 0, 1, 0, 0, 0, 8'd0);
        chk("z_os_done", 32'(done), 32'd1);
        cycle("z_os_end", 0, 0, 0, 0, 0, 8'd0);
        chk("z_os_idle", 32'(busy), 32'd0);
        cycle("z_ar", 0, 1, 1, 0, 0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            cycle("z_ar_run", 0, 0, 0, i[0], 0, 8'd4);
            chk("z_ar_done", 32'(done), 32'd1);
        end
        cycle("z_ar_abort", 0, 0, 0, 0, 1, 8'd0);
        chk("z_ar_done_low", 32'(done), 32'd0);

        // Abort at count 4; start+abort together in IDLE
        cycle("ab_start", 0, 1, 0, 0, 0, 8'd8);
        for (int i = 0; i < 4; i++) cycle("ab_run", 0, 0, 0, 0, 0, 8'd8);
        chk("ab_at4", 32'(count), 32'd4);
        cycle("ab_abort", 0, 0, 0, 1, 1, 8'd8);
        chk("ab_count", 32'(count), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        cycle("ab_both", 0, 1, 0, 0, 1, 8'd8);
        chk("ab_both_busy", 32'(busy), 32'd0);

        // Reset at count 6 with start held
        cycle("rs_start", 0, 1, 0, 0, 0, 8'd9);
        for (int i = 0; i < 3; i++) cycle("rs_run", 0, 1, 0, 0, 0, 8'd9);
        chk("rs_at6", 32'(count), 32'd6);
        cycle("rs_rst", 1, 1, 0, 0, 0, 8'd9);
        chk("rs_all0", 32'({count, busy, done}), 32'd0);
        cycle("rs_rst2", 1, 1, 0, 0, 0, 8'd9);
        cycle("rs_restart", 0, 1, 0, 0, 0, 8'd9);
        chk("rs_restart_count", 32'(count), 32'd9);
        chk("rs_restart_busy", 32'(busy), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit r, s, ar, p, a;
            logic [W-1:0] lv;
            r  = ($urandom_range(0, 59) == 0);
            a  = ($urandom_range(0, 24) == 0);
            s  = ($urandom_range(0, 2) == 0);
            p  = ($urandom_range(0, 3) == 0);
            ar = $urandom_range(0, 1) == 1;
            lv = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            cycle("rand", r, s, ar, p, a, lv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
